// File: rtl/joy_pkg.sv
// Shared definitions for the serial joystick link: button bit positions,
// frame geometry and the transmit FSM encoding.
package joy_pkg;

    localparam int unsigned START = 7;
    localparam int unsigned FIRE3 = 6;
    localparam int unsigned FIRE2 = 5;
    localparam int unsigned FIRE1 = 4;
    localparam int unsigned RIGHT = 3;
    localparam int unsigned LEFT  = 2;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned UP    = 0;

    localparam int unsigned FRAME_BITS       = 16;
    localparam int unsigned SHIFTS_PER_FRAME = 15;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    // Buttons are active-high on the pads but active-low on the wire.
    function automatic logic [FRAME_BITS-1:0] pack_word(input logic [7:0] pad1,
                                                       input logic [7:0] pad2);
        return ~{pad1, pad2};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third stage for single-cycle rise/fall pulses.
module sync_edge #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
            s3_q <= RESET_VAL;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/joy_serializer.sv
// Transmit side of the two-pad serial joystick link: emulates a 16-bit
// parallel-in/serial-out chain clocked by the host's JOY_CLK/JOY_LOAD.
module joy_serializer
    import joy_pkg::*;
#(
    parameter int unsigned DEB_DIV = 1024,
    parameter logic        FILL    = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       joy_clk,
    input  logic       joy_load,
    output logic       joy_data,
    input  logic [7:0] btn_joy1,
    input  logic [7:0] btn_joy2,
    output logic       frame_done,
    output logic       short_frame,
    output logic       overrun,
    input  logic       clr_err
);

    localparam logic [3:0] CNT_MAX = 4'(SHIFTS_PER_FRAME);

    logic clk_s, clk_rise, unused_clk_fall;
    logic load_s, load_rise, load_fall;
    logic [15:0] btn_s, btn_deb, unused_btn_rise, unused_btn_fall;
    logic [FRAME_BITS-1:0] word;

    sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_clk (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (joy_clk),
        .sync    (clk_s),
        .rise    (clk_rise),
        .fall    (unused_clk_fall)
    );

    // Load idles high, so reset to 1 to avoid a spurious load after reset.
    sync_edge #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_load (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (joy_load),
        .sync    (load_s),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    sync_edge #(.WIDTH(16), .RESET_VAL(16'h0000)) u_sync_btn (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     ({btn_joy1, btn_joy2}),
        .sync    (btn_s),
        .rise    (unused_btn_rise),
        .fall    (unused_btn_fall)
    );

    if (DEB_DIV == 0) begin : g_no_deb
        assign btn_deb = btn_s;
    end else begin : g_deb
        localparam int unsigned CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

        logic [CW-1:0] div_q;
        logic [15:0]   samp_q, deb_q, agree;
        logic          tick;

        assign tick  = (div_q == CW'(DEB_DIV - 1));
        assign agree = ~(btn_s ^ samp_q);

        // A bit follows its input only when two successive ticks saw the same level.
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                div_q  <= '0;
                samp_q <= '0;
                deb_q  <= '0;
            end else begin
                div_q <= tick ? '0 : div_q + CW'(1);
                if (tick) begin
                    samp_q <= btn_s;
                    deb_q  <= (agree & btn_s) | (~agree & deb_q);
                end
            end
        end

        assign btn_deb = deb_q;
    end

    assign word = pack_word(btn_deb[15:8], btn_deb[7:0]);

    logic [1:0]  state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovr_frame_q, ovr_frame_d;
    logic        data_q;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ovr_frame_d = ovr_frame_q;
        done_d      = 1'b0;
        short_d     = short_q & ~clr_err;
        overrun_d   = overrun_q & ~clr_err;

        case (state_q)
            IDLE:    if (!load_s) state_d = LOAD;
            LOAD:    if (load_rise) state_d = SHIFT;
            SHIFT:   if (load_fall) state_d = LOAD;
            default: state_d = IDLE;
        endcase

        // Only a load that ends a shifting frame is judged; the first after reset is not.
        if (load_fall && state_q == SHIFT) begin
            if (cnt_q == CNT_MAX && !ovr_frame_q) begin
                done_d = 1'b1;
            end else if (cnt_q < CNT_MAX) begin
                short_d = 1'b1;
            end
        end

        if (!load_s) begin
            shreg_d     = word;
            cnt_d       = '0;
            ovr_frame_d = 1'b0;
        end else if (clk_rise && state_q != IDLE) begin
            shreg_d = {shreg_q[14:0], FILL};
            if (cnt_q == CNT_MAX) begin
                overrun_d   = 1'b1;
                ovr_frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= 16'hFFFF;
            cnt_q       <= '0;
            ovr_frame_q <= 1'b0;
            data_q      <= 1'b1;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ovr_frame_q <= ovr_frame_d;
            data_q      <= shreg_q[15];
            done_q      <= done_d;
            short_q     <= short_d;
            overrun_q   <= overrun_d;
        end
    end

    assign joy_data    = data_q;
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign overrun     = overrun_q;

endmodule
